// File: rtl/timing_pkg.sv
// timing_pkg: shared state type, width helper and stage decoder for the timing ring
package timing_pkg;
  typedef enum logic {IDLE, RUN} state_t;
  function automatic int clog2_min1(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  function automatic logic [15:0] onehot(input int idx);
    return 16'b1 << idx;
  endfunction
endpackage

// File: rtl/ring_divider.sv
// ring_divider: counts DIV enabled clocks and flags the clock on which the ring steps
module ring_divider
  import timing_pkg::*;
#(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int DIV_W = clog2_min1(DIV);
  logic [DIV_W-1:0] r_cnt;
  logic w_wrap;
  assign w_wrap = r_cnt == DIV_W'(DIV - 1);
  assign tick = en && w_wrap;
  always_ff @(posedge clk)
    if (rst || clr) r_cnt <= '0;
    else if (en) r_cnt <= w_wrap ? '0 : r_cnt + DIV_W'(1);
endmodule

// File: rtl/timing_ring_gen.sv
// timing_ring_gen: one-hot timing ring stepped by a clock divider with start/stop/single/hold control
module timing_ring_gen
  import timing_pkg::*;
#(
  parameter int STAGES = 5,
  parameter int DIV = 2,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop_req,
  input  logic              single_mode,
  input  logic              hold,
  output logic [STAGES-1:0] gate,
  output logic              tick,
  output logic              cycle_start,
  output logic              cycle_end,
  output logic              running,
  output logic [CNT_W-1:0]  cycle_count
);
  localparam int PW = clog2_min1(STAGES);
  state_t r_state, w_next;
  logic [PW-1:0] r_pos;
  logic [CNT_W-1:0] r_cnt;
  logic r_stop, r_tick, r_cs, r_ce;
  logic w_start, w_adv, w_last, w_done, w_en;
  assign w_start = r_state == IDLE && start && !hold;
  assign w_en = r_state == RUN && !hold;
  assign w_last = w_adv && r_pos == PW'(STAGES - 1);
  assign w_done = w_last && (r_stop || single_mode);
  ring_divider #(.DIV(DIV)) u_div (
    .clk(clk),
    .rst(rst),
    .en(w_en),
    .clr(w_start),
    .tick(w_adv)
  );
  always_ff @(posedge clk)
    r_state <= rst ? IDLE : w_next;
  always_comb
    w_next = r_state == IDLE ? (w_start ? RUN : IDLE) : (w_done ? IDLE : RUN);
  always_comb begin
    running = r_state == RUN;
    gate = r_state == RUN ? STAGES'(onehot(int'(r_pos))) : '0;
  end
  always_ff @(posedge clk)
    if (rst) begin
      r_pos <= '0;
      r_cnt <= '0;
      r_stop <= 1'b0;
      r_tick <= 1'b0;
      r_cs <= 1'b0;
      r_ce <= 1'b0;
    end else begin
      r_tick <= w_adv;
      r_cs <= w_start || (w_last && !w_done);
      r_ce <= w_last;
      r_pos <= (w_start || w_last) ? '0 : w_adv ? r_pos + PW'(1) : r_pos;
      r_cnt <= r_cnt + CNT_W'(w_last);
      r_stop <= !w_done && (r_stop || (stop_req && (r_state == RUN || w_start)));
    end
  assign tick = r_tick;
  assign cycle_start = r_cs;
  assign cycle_end = r_ce;
  assign cycle_count = r_cnt;
endmodule

// File: tb/tb_timing_ring_gen.sv
// tb_timing_ring_gen: scoreboard bench for the timing ring (5 stages / DIV 2 and 3 stages / DIV 1)
module tb_timing_ring_gen;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, stop_req = 1'b0, single_mode = 1'b0, hold = 1'b0;
  logic [4:0] gate;
  logic tick, cycle_start, cycle_end, running;
  logic [7:0] cycle_count;
  logic s_start = 1'b0, s_stop = 1'b0, s_single = 1'b0, s_hold = 1'b0;
  logic [2:0] s_gate;
  logic s_tick, s_cs, s_ce, s_running;
  logic [1:0] s_count;
  logic [16:0] obs;
  logic [8:0] obs3;
  logic [16:0] sb[$];
  logic [8:0] sb3[$];
  logic [16:0] e;
  logic [8:0] e3;
  int n_tests = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  timing_ring_gen dut (
    .clk(clk), .rst(rst), .start(start), .stop_req(stop_req), .single_mode(single_mode), .hold(hold),
    .gate(gate), .tick(tick), .cycle_start(cycle_start), .cycle_end(cycle_end), .running(running),
    .cycle_count(cycle_count)
  );
  timing_ring_gen #(.STAGES(3), .DIV(1), .CNT_W(2)) dut3 (
    .clk(clk), .rst(rst), .start(s_start), .stop_req(s_stop), .single_mode(s_single), .hold(s_hold),
    .gate(s_gate), .tick(s_tick), .cycle_start(s_cs), .cycle_end(s_ce), .running(s_running),
    .cycle_count(s_count)
  );
  assign obs = {gate, tick, cycle_start, cycle_end, running, cycle_count};
  assign obs3 = {s_gate, s_tick, s_cs, s_ce, s_running, s_count};
  function automatic logic [16:0] exp5(input int j, input int base, input bit ends);
    logic [4:0] g;
    logic [7:0] c;
    if (ends && j >= 10) begin
      c = 8'(base + 1);
      return {5'b0, j == 10, 1'b0, j == 10, 1'b0, c};
    end
    g = 5'b1 << ((j / 2) % 5);
    c = 8'(base + j / 10);
    return {g, j > 0 && j % 2 == 0, j % 10 == 0, j > 0 && j % 10 == 0, 1'b1, c};
  endfunction
  function automatic logic [8:0] exp3(input int j);
    logic [2:0] g;
    g = 3'b1 << (j % 3);
    return {g, j > 0, j % 3 == 0, j > 0 && j % 3 == 0, 1'b1, 2'(j / 3)};
  endfunction
  task automatic do_rst();
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask
  task automatic test_reset();
    start = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_tests++;
    if (obs !== 17'h0) begin n_fail++; $display("FAIL reset got %h want %h", obs, 17'h0); end
    n_tests++;
    if (obs3 !== 9'h0) begin n_fail++; $display("FAIL reset3 got %h want %h", obs3, 9'h0); end
    rst = 1'b0;
    start = 1'b0;
  endtask
  task automatic test_basic();
    start = 1'b1;
    for (int j = 0; j < 22; j++) sb.push_back(exp5(j, 0, 0));
    for (int j = 0; j < 22; j++) begin
      @(posedge clk);
      #1 start = 1'b0;
      e = sb.pop_front();
      n_tests++;
      if (obs !== e) begin n_fail++; $display("FAIL basic j=%0d got %h want %h", j, obs, e); end
    end
  endtask
  task automatic test_reset_mid();
    for (int j = 22; j < 25; j++) sb.push_back(exp5(j, 0, 0));
    for (int j = 22; j < 25; j++) begin
      @(posedge clk);
      #1;
      e = sb.pop_front();
      n_tests++;
      if (obs !== e) begin n_fail++; $display("FAIL reset_mid pre j=%0d got %h want %h", j, obs, e); end
    end
    rst = 1'b1;
    sb.push_back(17'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    e = sb.pop_front();
    n_tests++;
    if (obs !== e) begin n_fail++; $display("FAIL reset_mid dark got %h want %h", obs, e); end
    start = 1'b1;
    for (int j = 0; j < 4; j++) sb.push_back(exp5(j, 0, 0));
    for (int j = 0; j < 4; j++) begin
      @(posedge clk);
      #1 start = 1'b0;
      e = sb.pop_front();
      n_tests++;
      if (obs !== e) begin n_fail++; $display("FAIL reset_mid restart j=%0d got %h want %h", j, obs, e); end
    end
  endtask
  task automatic test_single();
    do_rst();
    single_mode = 1'b1;
    start = 1'b1;
    for (int j = 0; j < 60; j++) sb.push_back(exp5(j, 0, 1));
    for (int j = 0; j < 60; j++) begin
      @(posedge clk);
      #1 start = 1'b0;
      e = sb.pop_front();
      n_tests++;
      if (obs !== e) begin n_fail++; $display("FAIL single j=%0d got %h want %h", j, obs, e); end
    end
    single_mode = 1'b0;
  endtask
  task automatic test_stop();
    start = 1'b1;
    for (int j = 0; j < 16; j++) sb.push_back(exp5(j, 1, 1));
    for (int j = 0; j < 16; j++) begin
      @(posedge clk);
      #1 start = 1'b0;
      stop_req = j == 4;
      e = sb.pop_front();
      n_tests++;
      if (obs !== e) begin n_fail++; $display("FAIL stop j=%0d got %h want %h", j, obs, e); end
    end
    start = 1'b1;
    for (int j = 0; j < 13; j++) sb.push_back(exp5(j, 2, 0));
    for (int j = 0; j < 13; j++) begin
      @(posedge clk);
      #1 start = 1'b0;
      e = sb.pop_front();
      n_tests++;
      if (obs !== e) begin n_fail++; $display("FAIL stop_cleared j=%0d got %h want %h", j, obs, e); end
    end
  endtask
  task automatic test_same_edge();
    do_rst();
    start = 1'b1;
    stop_req = 1'b1;
    for (int j = 0; j < 14; j++) sb.push_back(exp5(j, 0, 1));
    for (int j = 0; j < 14; j++) begin
      @(posedge clk);
      #1 start = 1'b0;
      stop_req = 1'b0;
      e = sb.pop_front();
      n_tests++;
      if (obs !== e) begin n_fail++; $display("FAIL same_edge j=%0d got %h want %h", j, obs, e); end
    end
  endtask
  task automatic test_hold();
    do_rst();
    hold = 1'b1;
    start = 1'b1;
    for (int j = 0; j < 3; j++) sb.push_back(17'h0);
    for (int j = 0; j < 3; j++) begin
      @(posedge clk);
      #1;
      e = sb.pop_front();
      n_tests++;
      if (obs !== e) begin n_fail++; $display("FAIL hold_idle j=%0d got %h want %h", j, obs, e); end
    end
    hold = 1'b0;
    for (int k = 0; k < 25; k++)
      sb.push_back(k <= 6 ? exp5(k, 0, 1) : k <= 13 ? {5'b01000, 4'b0001, 8'd0} : exp5(k - 7, 0, 1));
    for (int k = 0; k < 25; k++) begin
      @(posedge clk);
      #1 start = 1'b0;
      if (k == 6) hold = 1'b1;
      if (k == 13) hold = 1'b0;
      stop_req = k == 6;
      e = sb.pop_front();
      n_tests++;
      if (obs !== e) begin n_fail++; $display("FAIL hold k=%0d got %h want %h", k, obs, e); end
    end
  endtask
  task automatic test_ring3();
    s_start = 1'b1;
    for (int j = 0; j < 16; j++) sb3.push_back(exp3(j));
    for (int j = 0; j < 16; j++) begin
      @(posedge clk);
      #1 s_start = 1'b0;
      e3 = sb3.pop_front();
      n_tests++;
      if (obs3 !== e3) begin n_fail++; $display("FAIL ring3 j=%0d got %h want %h", j, obs3, e3); end
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    #2;
    test_reset();
    test_basic();
    test_reset_mid();
    test_single();
    test_stop();
    test_same_edge();
    test_hold();
    test_ring3();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/timing_ring_gen.md
Name: timing_ring_gen

Overview:
- Parametrised successor to the hardwired SDTRL clock section: a 1 MC oscillator feeds a binary trigger, which steps a fixed five-trigger timing ring.
- This block generalises the stage count and the divide ratio.
- Adds controls the card version lacks: start/stop, a single-cycle mode, an immediate hold, and a completed-cycle counter.
- Sits between the oscillator/power-on-reset logic and the core's timing-gate consumers: memory cycle, adder, and light drivers.

Parameters:
- STAGES, 5, number of ring stages (timing gates); legal range 2..16
- DIV, 2, oscillator clocks per ring step (binary trigger = 2); legal range 1..16
- CNT_W, 8, width of the completed-cycle counter

Ports:
- clk  in  1  oscillator clock
- rst  in  1  synchronous active-high reset; acts on the clk edge only
- start  in  1  level-sampled request to begin ring operation
- stop_req  in  1  request to stop at the end of the current ring cycle
- single_mode  in  1  when 1, run exactly one ring cycle per start
- hold  in  1  freezes divider, ring and counter immediately while 1
- gate  out  STAGES  one-hot timing gate; all zero when idle
- tick  out  1  one-clk pulse on the clock where the ring advances
- cycle_start  out  1  one-clk pulse coincident with gate[0] becoming active
- cycle_end  out  1  one-clk pulse when the last stage retires
- running  out  1  high whenever the ring is active
- cycle_count  out  CNT_W  completed ring cycles; wraps modulo 2^CNT_W

Behaviour:
- Reset: state=IDLE; gate=0, tick=0, cycle_start=0, cycle_end=0, running=0, cycle_count=0, divider=0, stop_pending=0. Reset overrides all other inputs, including mid-cycle; the ring goes dark on the next edge.
- States: IDLE, RUN.
- IDLE → RUN: on an edge where start=1 and hold=0.
  - Next clock: gate=1 (stage 0), cycle_start=1, running=1, divider=0.
- RUN, hold=0:
  - divider increments each clk.
  - When divider==DIV-1: divider←0, tick=1, ring advances one stage.
  - Consequently each stage is active for exactly DIV clocks.
- Advance from stage STAGES-1:
  - cycle_end=1 and cycle_count+1 on the same edge.
  - If stop_pending or single_mode: go to IDLE; gate=0, running=0, stop_pending←0.
  - Otherwise: wrap to stage 0 and pulse cycle_start.
- stop_req=1 in RUN sets stop_pending; the current cycle always completes. No partial cycles.
- start in RUN is ignored.
- start and stop_req in the same IDLE edge: start is taken and stop_pending is set, so exactly one cycle runs.
- hold=1:
  - divider, ring position, counter and stop_pending are frozen; gate keeps its value.
  - tick, cycle_start and cycle_end are forced to 0.
  - stop_req is still latched.
  - In IDLE, hold blocks start.
- single_mode is sampled at the last-stage advance; changing it mid-cycle affects only that decision.
- DIV=1: tick is high every clk in RUN.
- Pulse outputs are registered. gate never has two bits set, and is zero only in IDLE.

Decomposition:
- Shared package timing_pkg:
  - state enum (IDLE, RUN)
  - localparam DIV_W = $clog2(DIV) (min 1)
  - one-hot helper function for stage index → gate vector
- One sub-module, ring_divider: parameter DIV; ports clk, rst, en, clr; output tick.
- FSM, ring shift register, stop latch and counter stay in timing_ring_gen.

Test Plan (STAGES=5, DIV=2 unless stated):
- start pulse at edge t → running=1 and gate=00001 with cycle_start at t+1; gate=00010 at t+3, 00100 at t+5, 01000 at t+7, 10000 at t+9; gate=00001 with cycle_start and cycle_end at t+11; cycle_count=1.
- single_mode=1, start → one cycle exactly; at t+11 gate=00000, running=0, cycle_end=1, cycle_count=1; no further ticks over 50 clocks.
- stop_req pulse while gate=00100 → ring continues through 10000, enters IDLE at the last-stage retire; cycle_count increments once; stop_pending clears.
- hold high for 7 clocks while gate=01000 → gate stays 01000, no tick; after release the stage lasts its remaining clocks, with a total active duration of 2 non-hold clocks.
- rst asserted mid-cycle at gate=00100 → next edge: all outputs 0, cycle_count=0; start afterwards restarts at stage 0.
- STAGES=3, DIV=1, CNT_W=2 free-running → tick every clock, gate rotates 001→010→100; cycle_count wraps 3→0 after the 4th cycle.
